// File: rtl/srt4_arbiter_if.sv
// Bundles the two-requester operand/result bus and the shared srt4 divider bus.
// The arbiter uses the slave side; requesters and the divider use the master side.
interface srt4_arbiter_if;
  logic [1:0] req;
  logic [7:0] dividend0;
  logic [7:0] divisor0;
  logic [7:0] dividend1;
  logic [7:0] divisor1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_begin;
  logic [7:0] div_inbus;
  logic [7:0] div_outbus;
  logic       div_end;

  modport slave (
    input  req, dividend0, divisor0, dividend1, divisor1, div_outbus, div_end,
    output gnt, done, err, quotient, remainder, div_begin, div_inbus
  );

  modport master (
    output req, dividend0, divisor0, dividend1, divisor1, div_outbus, div_end,
    input  gnt, done, err, quotient, remainder, div_begin, div_inbus
  );
endinterface

// File: rtl/srt4_arbiter.sv
// Round-robin sequencer sharing one srt4 radix-4 divider between two requesters,
// with divide-by-zero screening and a WAIT-state timeout.
module srt4_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_b,
  srt4_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_BEGIN, S_LOAD_A, S_LOAD_B, S_WAIT, S_RD_R, S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       div_begin_q, div_begin_d;
  logic [7:0] div_inbus_q, div_inbus_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [7:0] quot_tmp_q, quot_tmp_d;
  logic [1:0] owner_onehot;

  assign owner_onehot = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    err_d       = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_begin_d = 1'b0;
    div_inbus_d = 8'h00;
    tmo_d       = tmo_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    quot_tmp_d  = quot_tmp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          // Both requesting: the one not served last wins.
          owner_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          last_d  = owner_d;
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          op_a_d  = owner_d ? bus.dividend1 : bus.dividend0;
          op_b_d  = owner_d ? bus.divisor1  : bus.divisor0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_b_q == 8'h00) begin
          quotient_d  = 8'hFF;
          remainder_d = op_a_q;
          err_d       = 1'b1;
          done_d      = owner_onehot;
          gnt_d       = 2'b00;
          state_d     = S_DONE;
        end else begin
          div_begin_d = 1'b1;
          state_d     = S_BEGIN;
        end
      end
      S_BEGIN: begin
        div_inbus_d = op_a_q;
        state_d     = S_LOAD_A;
      end
      S_LOAD_A: begin
        div_inbus_d = op_b_q;
        state_d     = S_LOAD_B;
      end
      S_LOAD_B: begin
        tmo_d   = 8'h00;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Quotient is staged so the visible result only changes with done.
        if (bus.div_end) begin
          quot_tmp_d = bus.div_outbus;
          state_d    = S_RD_R;
        end else if (tmo_q == TMO_LAST) begin
          quotient_d  = 8'hFF;
          remainder_d = 8'hFF;
          err_d       = 1'b1;
          done_d      = owner_onehot;
          gnt_d       = 2'b00;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'h01;
        end
      end
      S_RD_R: begin
        quotient_d  = quot_tmp_q;
        remainder_d = bus.div_outbus;
        done_d      = owner_onehot;
        gnt_d       = 2'b00;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
      quotient_q  <= 8'h00;
      remainder_q <= 8'h00;
      div_begin_q <= 1'b0;
      div_inbus_q <= 8'h00;
      tmo_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_begin_q <= div_begin_d;
      div_inbus_q <= div_inbus_d;
      tmo_q       <= tmo_d;
    end
  end

  // Operand and staging registers carry data only; they need no reset.
  always_ff @(posedge clk) begin
    op_a_q     <= op_a_d;
    op_b_q     <= op_b_d;
    quot_tmp_q <= quot_tmp_d;
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_begin = div_begin_q;
  assign bus.div_inbus = div_inbus_q;

endmodule

// File: tb/tb_srt4_arbiter.sv
// Directed bench for srt4_arbiter with a small behavioural divider model.
module tb_srt4_arbiter;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  srt4_arbiter_if ifc ();

  srt4_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int failures = 0;

  // Divider model: begin, dividend, divisor, short latency, quotient+end, remainder.
  logic       hang = 1'b0;
  logic       spur_end = 1'b0;
  logic [7:0] spur_out = 8'h00;
  int         m_ph;
  int         m_cnt;
  logic [7:0] m_a, m_b, m_out;
  logic       m_end;

  always @(posedge clk) begin
    if (rst_b) begin
      m_ph <= 0; m_cnt <= 0; m_end <= 1'b0; m_out <= 8'h00;
    end else begin
      case (m_ph)
        0: if (ifc.div_begin) m_ph <= 1;
        1: begin m_a <= ifc.div_inbus; m_ph <= 2; end
        2: begin m_b <= ifc.div_inbus; m_cnt <= 0; m_ph <= 3; end
        3: if (!hang) begin
             if (m_cnt == 2) begin
               m_end <= 1'b1;
               m_out <= (m_b != 8'h00) ? m_a / m_b : 8'hFF;
               m_ph  <= 4;
             end else m_cnt <= m_cnt + 1;
           end
        4: begin m_end <= 1'b0; m_out <= (m_b != 8'h00) ? m_a % m_b : 8'hFF; m_ph <= 5; end
        default: begin m_out <= 8'h00; m_ph <= 0; end
      endcase
    end
  end

  assign ifc.div_end    = m_end | spur_end;
  assign ifc.div_outbus = spur_end ? spur_out : m_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b1; ifc.req = 2'b00; hang = 1'b0; spur_end = 1'b0;
    tick(); tick();
    rst_b = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (ifc.done != 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    ifc.dividend0 = 8'd0; ifc.divisor0 = 8'd0; ifc.dividend1 = 8'd0; ifc.divisor1 = 8'd0;
    do_reset();
    checks++; if (ifc.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", ifc.gnt); end
    checks++; if (ifc.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", ifc.done); end
    checks++; if (ifc.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ifc.err); end
    checks++; if (ifc.quotient !== 8'h00 || ifc.remainder !== 8'h00) begin failures++;
      $display("FAIL reset_results got=%h/%h exp=00/00", ifc.quotient, ifc.remainder); end
    checks++; if (ifc.div_begin !== 1'b0 || ifc.div_inbus !== 8'h00) begin failures++;
      $display("FAIL reset_divbus got=%b/%h exp=0/00", ifc.div_begin, ifc.div_inbus); end
  endtask

  task automatic test_single();
    bit ok;
    ifc.dividend0 = 8'd100; ifc.divisor0 = 8'd7; ifc.req = 2'b01;
    tick();
    checks++; if (ifc.gnt !== 2'b01 || ifc.div_begin !== 1'b0) begin failures++;
      $display("FAIL single_grant got gnt=%b begin=%b exp gnt=01 begin=0", ifc.gnt, ifc.div_begin); end
    tick();
    checks++; if (ifc.div_begin !== 1'b1 || ifc.div_inbus !== 8'h00) begin failures++;
      $display("FAIL single_begin got begin=%b inbus=%0d exp begin=1 inbus=0", ifc.div_begin, ifc.div_inbus); end
    tick();
    checks++; if (ifc.div_begin !== 1'b0 || ifc.div_inbus !== 8'd100) begin failures++;
      $display("FAIL single_load_a got begin=%b inbus=%0d exp begin=0 inbus=100", ifc.div_begin, ifc.div_inbus); end
    tick();
    checks++; if (ifc.div_inbus !== 8'd7) begin failures++;
      $display("FAIL single_load_b got inbus=%0d exp=7", ifc.div_inbus); end
    wait_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_wait got=no_done exp=done"); end
    ifc.req = 2'b00;
    checks++; if (ifc.done !== 2'b01 || ifc.err !== 1'b0 || ifc.gnt !== 2'b00) begin failures++;
      $display("FAIL single_done got done=%b err=%b gnt=%b exp done=01 err=0 gnt=00", ifc.done, ifc.err, ifc.gnt); end
    checks++; if (ifc.quotient !== 8'd14 || ifc.remainder !== 8'd2) begin failures++;
      $display("FAIL single_result got=%0d/%0d exp=14/2", ifc.quotient, ifc.remainder); end
    tick();
    checks++; if (ifc.done !== 2'b00 || ifc.quotient !== 8'd14) begin failures++;
      $display("FAIL single_pulse got done=%b q=%0d exp done=00 q=14", ifc.done, ifc.quotient); end
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0] eg;
    logic [7:0] eq, er;
    do_reset();
    ifc.dividend0 = 8'd100; ifc.divisor0 = 8'd7;
    ifc.dividend1 = 8'd255; ifc.divisor1 = 8'd16;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      eq = (i % 2 == 1) ? 8'd15 : 8'd14;
      er = (i % 2 == 1) ? 8'd15 : 8'd2;
      if (i == 0) begin
        ifc.req = 2'b11;
        tick();
      end else begin
        tick();
        checks++; if (ifc.gnt !== 2'b00) begin failures++;
          $display("FAIL contend_idle_gap%0d got=%b exp=00", i, ifc.gnt); end
        tick();
      end
      checks++; if (ifc.gnt !== eg) begin failures++;
        $display("FAIL contend_gnt%0d got=%b exp=%b", i, ifc.gnt, eg); end
      wait_done(40, ok);
      checks++; if (!ok) begin failures++; $display("FAIL contend_wait%0d got=no_done exp=done", i); end
      if (i == 3) ifc.req = 2'b00;
      checks++; if (ifc.done !== eg || ifc.err !== 1'b0) begin failures++;
        $display("FAIL contend_done%0d got done=%b err=%b exp done=%b err=0", i, ifc.done, ifc.err, eg); end
      checks++; if (ifc.quotient !== eq || ifc.remainder !== er) begin failures++;
        $display("FAIL contend_result%0d got=%0d/%0d exp=%0d/%0d", i, ifc.quotient, ifc.remainder, eq, er); end
    end
    tick();
  endtask

  task automatic test_div_zero();
    ifc.dividend1 = 8'd42; ifc.divisor1 = 8'd0; ifc.req = 2'b10;
    tick();
    checks++; if (ifc.gnt !== 2'b10 || ifc.div_begin !== 1'b0) begin failures++;
      $display("FAIL dz_grant got gnt=%b begin=%b exp gnt=10 begin=0", ifc.gnt, ifc.div_begin); end
    tick();
    ifc.req = 2'b00;
    checks++; if (ifc.done !== 2'b10 || ifc.err !== 1'b1 || ifc.div_begin !== 1'b0) begin failures++;
      $display("FAIL dz_done got done=%b err=%b begin=%b exp done=10 err=1 begin=0", ifc.done, ifc.err, ifc.div_begin); end
    checks++; if (ifc.quotient !== 8'hFF || ifc.remainder !== 8'd42) begin failures++;
      $display("FAIL dz_result got=%h/%0d exp=ff/42", ifc.quotient, ifc.remainder); end
    tick();
    checks++; if (ifc.done !== 2'b00 || ifc.err !== 1'b0 || ifc.div_begin !== 1'b0) begin failures++;
      $display("FAIL dz_after got done=%b err=%b begin=%b exp 00/0/0", ifc.done, ifc.err, ifc.div_begin); end
  endtask

  task automatic test_timeout();
    bit early;
    hang = 1'b1;
    ifc.dividend0 = 8'd50; ifc.divisor0 = 8'd5; ifc.req = 2'b01;
    tick(); tick(); tick(); tick();
    checks++; if (ifc.div_inbus !== 8'd5) begin failures++;
      $display("FAIL tmo_load_b got inbus=%0d exp=5", ifc.div_inbus); end
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ifc.done !== 2'b00) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL tmo_early got=done_before_9 exp=none"); end
    tick();
    ifc.req = 2'b00;
    checks++; if (ifc.done !== 2'b01 || ifc.err !== 1'b1) begin failures++;
      $display("FAIL tmo_done got done=%b err=%b exp done=01 err=1", ifc.done, ifc.err); end
    checks++; if (ifc.quotient !== 8'hFF || ifc.remainder !== 8'hFF) begin failures++;
      $display("FAIL tmo_result got=%h/%h exp=ff/ff", ifc.quotient, ifc.remainder); end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    ifc.dividend0 = 8'd100; ifc.divisor0 = 8'd7; ifc.req = 2'b01;
    tick(); tick(); tick(); tick(); tick();
    rst_b = 1'b1; ifc.req = 2'b00;
    tick();
    checks++; if (ifc.gnt !== 2'b00 || ifc.done !== 2'b00 || ifc.err !== 1'b0) begin failures++;
      $display("FAIL rstwait_ctrl got gnt=%b done=%b err=%b exp 00/00/0", ifc.gnt, ifc.done, ifc.err); end
    checks++; if (ifc.quotient !== 8'h00 || ifc.remainder !== 8'h00 || ifc.div_inbus !== 8'h00) begin failures++;
      $display("FAIL rstwait_data got q=%h r=%h inbus=%h exp 00/00/00", ifc.quotient, ifc.remainder, ifc.div_inbus); end
    rst_b = 1'b0;
    ifc.dividend0 = 8'd200; ifc.divisor0 = 8'd9; ifc.req = 2'b01;
    wait_done(40, ok);
    ifc.req = 2'b00;
    checks++; if (!ok || ifc.done !== 2'b01 || ifc.err !== 1'b0) begin failures++;
      $display("FAIL rstwait_redo got ok=%b done=%b err=%b exp 1/01/0", ok, ifc.done, ifc.err); end
    checks++; if (ifc.quotient !== 8'd22 || ifc.remainder !== 8'd2) begin failures++;
      $display("FAIL rstwait_result got=%0d/%0d exp=22/2", ifc.quotient, ifc.remainder); end
    tick();
  endtask

  task automatic test_spurious_and_latch();
    bit ok;
    bit bad;
    spur_out = 8'h55; spur_end = 1'b1; bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ifc.gnt !== 2'b00 || ifc.done !== 2'b00 || ifc.div_begin !== 1'b0 || ifc.quotient !== 8'd22) bad = 1'b1;
    end
    spur_end = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++;
      $display("FAIL spurious_end got=reacted exp=ignored (q=%0d)", ifc.quotient); end
    ifc.dividend1 = 8'd61; ifc.divisor1 = 8'd4; ifc.req = 2'b10;
    tick();
    checks++; if (ifc.gnt !== 2'b10) begin failures++; $display("FAIL latch_gnt got=%b exp=10", ifc.gnt); end
    ifc.dividend1 = 8'd99; ifc.divisor1 = 8'd0;
    wait_done(40, ok);
    ifc.req = 2'b00;
    checks++; if (!ok || ifc.done !== 2'b10 || ifc.err !== 1'b0) begin failures++;
      $display("FAIL latch_done got ok=%b done=%b err=%b exp 1/10/0", ok, ifc.done, ifc.err); end
    checks++; if (ifc.quotient !== 8'd15 || ifc.remainder !== 8'd1) begin failures++;
      $display("FAIL latch_result got=%0d/%0d exp=15/1", ifc.quotient, ifc.remainder); end
    tick();
  endtask

  initial begin
    ifc.req = 2'b00;
    test_reset();
    test_single();
    test_contention();
    test_div_zero();
    test_timeout();
    test_reset_mid_wait();
    test_spurious_and_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
